// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forward-select encoding
// and the load-use stall FSM state.
package hazard_pkg;

  // Source of an EX operand as seen by the operand multiplexer.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,  // register file (no forwarding)
    FWD_WB  = 2'b01,  // MEM/WB result
    FWD_MEM = 2'b10   // EX/MEM result
  } fwd_sel_t;

  // Load-use stall sequencer.
  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } hz_state_t;

endpackage : hazard_pkg

// File: rtl/fwd_match.sv
// Per-source comparator: decides where one ID source operand should come
// from once the instruction reaches EX, and flags a load-use conflict.
module fwd_match
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  logic                  rs_used_i,
  input  logic [REG_ADDR_W-1:0] id_ex_rd_i,
  input  logic                  id_ex_regwrite_i,
  input  logic                  id_ex_memread_i,
  input  logic [REG_ADDR_W-1:0] ex_mem_rd_i,
  input  logic                  ex_mem_regwrite_i,
  output fwd_sel_t              next_sel_o,
  output logic                  load_use_o
);

  logic match_id_ex;
  logic match_ex_mem;

  // x0 is hardwired to zero, so a producer targeting it never forwards.
  assign match_id_ex  = rs_used_i && id_ex_regwrite_i  && (id_ex_rd_i  != '0) && (id_ex_rd_i  == rs_i);
  assign match_ex_mem = rs_used_i && ex_mem_regwrite_i && (ex_mem_rd_i != '0) && (ex_mem_rd_i == rs_i);

  // Select the newest producer; a load in ID/EX cannot forward in time.
  always_comb begin
    // NOTE: every output gets a default before the branches so no latch is inferred.
    next_sel_o = FWD_RF;
    load_use_o = match_id_ex && id_ex_memread_i;
    if (match_id_ex && !id_ex_memread_i) begin
      next_sel_o = FWD_MEM;
    end else if (match_ex_mem) begin
      next_sel_o = FWD_WB;
    end
  end

endmodule : fwd_match

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage pipeline: registered EX forward selects,
// load-use stall/bubble sequencing and saturating performance counters.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            ext_stall,
  input  logic                            flush,
  input  logic                            id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]   id_rs,
  input  logic [NUM_SRC-1:0]              id_rs_used,
  input  logic [REG_ADDR_W-1:0]           id_ex_rd,
  input  logic [REG_ADDR_W-1:0]           ex_mem_rd,
  input  logic [REG_ADDR_W-1:0]           mem_wb_rd,
  input  logic                            id_ex_regwrite,
  input  logic                            ex_mem_regwrite,
  input  logic                            mem_wb_regwrite,
  input  logic                            id_ex_memread,
  output logic                            stall_if,
  output logic                            stall_id,
  output logic                            bubble_ex,
  output logic [2*NUM_SRC-1:0]            fwd_sel,
  output logic [CNT_W-1:0]                stall_cycles,
  output logic [CNT_W-1:0]                fwd_events
);

  localparam int              CW       = $clog2(LOAD_LAT + 1);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  hz_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*NUM_SRC-1:0] fwd_sel_q, fwd_sel_d;
  logic [CNT_W-1:0]     stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]     fwd_events_q, fwd_events_d;

  logic [2*NUM_SRC-1:0] next_sel;
  logic [NUM_SRC-1:0]   load_use_vec;
  logic                 load_use;

  // A MEM/WB producer has retired by the time the ID instruction reaches
  // EX; the register file writes before it reads, so no select needs it.
  logic unused_mem_wb;
  assign unused_mem_wb = ^{mem_wb_rd, mem_wb_regwrite};

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    fwd_match #(
      .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_match (
      .rs_i              (id_rs[k*REG_ADDR_W +: REG_ADDR_W]),
      .rs_used_i         (id_rs_used[k]),
      .id_ex_rd_i        (id_ex_rd),
      .id_ex_regwrite_i  (id_ex_regwrite),
      .id_ex_memread_i   (id_ex_memread),
      .ex_mem_rd_i       (ex_mem_rd),
      .ex_mem_regwrite_i (ex_mem_regwrite),
      .next_sel_o        (next_sel[2*k +: 2]),
      .load_use_o        (load_use_vec[k])
    );
  end

  assign load_use = id_valid && (|load_use_vec);

  // Stall sequencer: stall/bubble outputs and next state; flush always wins.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush) begin
          bubble_ex = 1'b1;
        end else if (load_use) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          bubble_ex = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = STALL;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      STALL: begin
        if (flush) begin
          bubble_ex = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
        end else begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          bubble_ex = 1'b1;
          cnt_d     = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  // Next forward selects (zeroed behind a bubble) and saturating counters.
  always_comb begin
    fwd_sel_d      = next_sel;
    stall_cycles_d = stall_cycles_q;
    fwd_events_d   = fwd_events_q;
    if (flush || bubble_ex) begin
      fwd_sel_d = '0;
    end
    if (stall_id && (stall_cycles_q != CNT_MAX)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
    if ((|fwd_sel_d) && (fwd_events_q != CNT_MAX)) begin
      fwd_events_d = fwd_events_q + CNT_W'(1);
    end
  end

  // State registers; ext_stall freezes everything except reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      fwd_sel_q      <= '0;
      stall_cycles_q <= '0;
      fwd_events_q   <= '0;
    end else if (!ext_stall) begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      fwd_sel_q      <= fwd_sel_d;
      stall_cycles_q <= stall_cycles_d;
      fwd_events_q   <= fwd_events_d;
    end
  end

  assign fwd_sel      = fwd_sel_q;
  assign stall_cycles = stall_cycles_q;
  assign fwd_events   = fwd_events_q;

endmodule : hazard_ctrl_unit

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: three instances share stimulus
// (A: LOAD_LAT=1, B: LOAD_LAT=3, C: LOAD_LAT=2 with 2-bit counters).
module tb_hazard_ctrl_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, ext_stall, flush, id_valid;
  logic [9:0] id_rs;
  logic [1:0] id_rs_used;
  logic [4:0] id_ex_rd, ex_mem_rd, mem_wb_rd;
  logic       id_ex_regwrite, ex_mem_regwrite, mem_wb_regwrite, id_ex_memread;

  logic        a_stall_if, a_stall_id, a_bubble;
  logic [3:0]  a_fwd_sel;
  logic [15:0] a_stall_cycles, a_fwd_events;
  logic        b_stall_if, b_stall_id, b_bubble;
  logic [3:0]  b_fwd_sel;
  logic [15:0] b_stall_cycles, b_fwd_events;
  logic        c_stall_if, c_stall_id, c_bubble;
  logic [3:0]  c_fwd_sel;
  logic [1:0]  c_stall_cycles, c_fwd_events;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_ctrl_unit u_dut_a (
    .clk (clk), .reset (reset), .ext_stall (ext_stall), .flush (flush),
    .id_valid (id_valid), .id_rs (id_rs), .id_rs_used (id_rs_used),
    .id_ex_rd (id_ex_rd), .ex_mem_rd (ex_mem_rd), .mem_wb_rd (mem_wb_rd),
    .id_ex_regwrite (id_ex_regwrite), .ex_mem_regwrite (ex_mem_regwrite),
    .mem_wb_regwrite (mem_wb_regwrite), .id_ex_memread (id_ex_memread),
    .stall_if (a_stall_if), .stall_id (a_stall_id), .bubble_ex (a_bubble),
    .fwd_sel (a_fwd_sel), .stall_cycles (a_stall_cycles), .fwd_events (a_fwd_events)
  );

  hazard_ctrl_unit #(.LOAD_LAT(3)) u_dut_b (
    .clk (clk), .reset (reset), .ext_stall (ext_stall), .flush (flush),
    .id_valid (id_valid), .id_rs (id_rs), .id_rs_used (id_rs_used),
    .id_ex_rd (id_ex_rd), .ex_mem_rd (ex_mem_rd), .mem_wb_rd (mem_wb_rd),
    .id_ex_regwrite (id_ex_regwrite), .ex_mem_regwrite (ex_mem_regwrite),
    .mem_wb_regwrite (mem_wb_regwrite), .id_ex_memread (id_ex_memread),
    .stall_if (b_stall_if), .stall_id (b_stall_id), .bubble_ex (b_bubble),
    .fwd_sel (b_fwd_sel), .stall_cycles (b_stall_cycles), .fwd_events (b_fwd_events)
  );

  hazard_ctrl_unit #(.LOAD_LAT(2), .CNT_W(2)) u_dut_c (
    .clk (clk), .reset (reset), .ext_stall (ext_stall), .flush (flush),
    .id_valid (id_valid), .id_rs (id_rs), .id_rs_used (id_rs_used),
    .id_ex_rd (id_ex_rd), .ex_mem_rd (ex_mem_rd), .mem_wb_rd (mem_wb_rd),
    .id_ex_regwrite (id_ex_regwrite), .ex_mem_regwrite (ex_mem_regwrite),
    .mem_wb_regwrite (mem_wb_regwrite), .id_ex_memread (id_ex_memread),
    .stall_if (c_stall_if), .stall_id (c_stall_id), .bubble_ex (c_bubble),
    .fwd_sel (c_fwd_sel), .stall_cycles (c_stall_cycles), .fwd_events (c_fwd_events)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    ext_stall       = 1'b0;
    flush           = 1'b0;
    id_valid        = 1'b0;
    id_rs           = '0;
    id_rs_used      = '0;
    id_ex_rd        = '0;
    ex_mem_rd       = '0;
    mem_wb_rd       = '0;
    id_ex_regwrite  = 1'b0;
    ex_mem_regwrite = 1'b0;
    mem_wb_regwrite = 1'b0;
    id_ex_memread   = 1'b0;
  endtask

  task automatic do_reset();
    quiet();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // lw x3 sits in ID/EX, the ID instruction reads x3 as source 0.
  task automatic set_load_hazard();
    quiet();
    id_valid       = 1'b1;
    id_rs          = {5'd0, 5'd3};
    id_rs_used     = 2'b01;
    id_ex_rd       = 5'd3;
    id_ex_regwrite = 1'b1;
    id_ex_memread  = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    quiet();

    // ---- reset state (A)
    do_reset();
    check("rst_stall_if", 32'(a_stall_if), 0);
    check("rst_stall_id", 32'(a_stall_id), 0);
    check("rst_bubble", 32'(a_bubble), 0);
    check("rst_fwd_sel", 32'(a_fwd_sel), 0);
    check("rst_stall_cycles", 32'(a_stall_cycles), 0);
    check("rst_fwd_events", 32'(a_fwd_events), 0);

    // ---- ALU back-to-back: add x5 in ID/EX, ID reads {x0,x5}
    id_valid = 1'b1; id_rs = {5'd5, 5'd0}; id_rs_used = 2'b11;
    id_ex_rd = 5'd5; id_ex_regwrite = 1'b1;
    #1;
    check("alu_no_stall", 32'(a_stall_id), 0);
    tick();
    check("alu_sel", 32'(a_fwd_sel), 'h8);
    check("alu_events", 32'(a_fwd_events), 1);

    // ---- x7 from both ID/EX and EX/MEM: newer wins
    id_rs = {5'd0, 5'd7}; id_rs_used = 2'b01;
    id_ex_rd = 5'd7; ex_mem_rd = 5'd7; ex_mem_regwrite = 1'b1;
    tick();
    check("both_sel_newer", 32'(a_fwd_sel), 'h2);

    // ---- rd = x0 never matches
    id_rs = '0; id_rs_used = 2'b11; id_ex_rd = 5'd0; ex_mem_rd = 5'd0;
    tick();
    check("x0_sel", 32'(a_fwd_sel), 'h0);

    // ---- src0=x4 from ID/EX, src1=x9 from EX/MEM
    id_rs = {5'd9, 5'd4}; id_ex_rd = 5'd4; ex_mem_rd = 5'd9;
    tick();
    check("mixed_sel", 32'(a_fwd_sel), 'h6);

    // ---- src0 not used: only src1 forwards
    id_rs_used = 2'b10;
    tick();
    check("unused_src_sel", 32'(a_fwd_sel), 'h4);

    // ---- ID/EX not writing: falls back to EX/MEM
    id_rs = {5'd0, 5'd4}; id_rs_used = 2'b01;
    id_ex_rd = 5'd4; id_ex_regwrite = 1'b0; ex_mem_rd = 5'd4;
    tick();
    check("nowrite_sel", 32'(a_fwd_sel), 'h1);
    check("events_after_alu", 32'(a_fwd_events), 5);

    // ---- load-use, LOAD_LAT=1 (A)
    do_reset();
    set_load_hazard();
    #1;
    check("lu1_stall_if", 32'(a_stall_if), 1);
    check("lu1_stall_id", 32'(a_stall_id), 1);
    check("lu1_bubble", 32'(a_bubble), 1);
    tick();
    check("lu1_sel_bubble", 32'(a_fwd_sel), 0);
    check("lu1_stall_cycles", 32'(a_stall_cycles), 1);
    id_ex_rd = '0; id_ex_regwrite = 1'b0; id_ex_memread = 1'b0;
    ex_mem_rd = 5'd3; ex_mem_regwrite = 1'b1;
    #1;
    check("lu1_released_stall", 32'(a_stall_id), 0);
    check("lu1_released_bubble", 32'(a_bubble), 0);
    tick();
    check("lu1_sel_wb", 32'(a_fwd_sel), 'h1);
    check("lu1_stall_cycles_after", 32'(a_stall_cycles), 1);
    check("lu1_events", 32'(a_fwd_events), 1);

    // ---- load-use, LOAD_LAT=3 (B)
    do_reset();
    set_load_hazard();
    #1;
    check("lu3_c0_stall", 32'(b_stall_id), 1);
    check("lu3_c0_bubble", 32'(b_bubble), 1);
    tick();
    id_ex_rd = '0; id_ex_regwrite = 1'b0; id_ex_memread = 1'b0;
    ex_mem_rd = 5'd3; ex_mem_regwrite = 1'b1;
    #1;
    check("lu3_c1_stall_if", 32'(b_stall_if), 1);
    check("lu3_c1_bubble", 32'(b_bubble), 1);
    check("lu3_c1_sel", 32'(b_fwd_sel), 0);
    tick();
    ex_mem_rd = '0; ex_mem_regwrite = 1'b0;
    mem_wb_rd = 5'd3; mem_wb_regwrite = 1'b1;
    #1;
    check("lu3_c2_stall", 32'(b_stall_id), 1);
    tick();
    mem_wb_rd = '0; mem_wb_regwrite = 1'b0;
    #1;
    check("lu3_c3_stall", 32'(b_stall_id), 0);
    check("lu3_c3_bubble", 32'(b_bubble), 0);
    check("lu3_stall_cycles", 32'(b_stall_cycles), 3);
    tick();
    check("lu3_final_sel", 32'(b_fwd_sel), 0);
    check("lu3_events", 32'(b_fwd_events), 0);

    // ---- flush in the 2nd stall cycle (B)
    do_reset();
    set_load_hazard();
    tick();
    id_ex_rd = '0; id_ex_regwrite = 1'b0; id_ex_memread = 1'b0;
    ex_mem_rd = 5'd3; ex_mem_regwrite = 1'b1;
    flush = 1'b1;
    #1;
    check("flush_bubble", 32'(b_bubble), 1);
    check("flush_stall_if", 32'(b_stall_if), 0);
    check("flush_stall_id", 32'(b_stall_id), 0);
    tick();
    check("flush_sel", 32'(b_fwd_sel), 0);
    flush = 1'b0;
    id_rs = '0; id_rs_used = '0;
    ex_mem_rd = '0; ex_mem_regwrite = 1'b0;
    mem_wb_rd = 5'd3; mem_wb_regwrite = 1'b1;
    #1;
    check("flush_idle_stall", 32'(b_stall_id), 0);
    check("flush_idle_bubble", 32'(b_bubble), 0);
    check("flush_stall_cycles", 32'(b_stall_cycles), 1);

    // ---- ext_stall held 4 cycles inside STALL (B)
    do_reset();
    set_load_hazard();
    tick();
    id_ex_rd = '0; id_ex_regwrite = 1'b0; id_ex_memread = 1'b0;
    ex_mem_rd = 5'd3; ex_mem_regwrite = 1'b1;
    ext_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("frz_stall_%0d", i), 32'(b_stall_id), 1);
      tick();
      check($sformatf("frz_cycles_%0d", i), 32'(b_stall_cycles), 1);
      check($sformatf("frz_sel_%0d", i), 32'(b_fwd_sel), 0);
    end
    ext_stall = 1'b0;
    #1;
    check("frz_rel_stall0", 32'(b_stall_id), 1);
    tick();
    check("frz_rel_cycles0", 32'(b_stall_cycles), 2);
    ex_mem_rd = '0; ex_mem_regwrite = 1'b0;
    mem_wb_rd = 5'd3; mem_wb_regwrite = 1'b1;
    #1;
    check("frz_rel_stall1", 32'(b_stall_id), 1);
    tick();
    check("frz_rel_cycles1", 32'(b_stall_cycles), 3);
    mem_wb_rd = '0; mem_wb_regwrite = 1'b0;
    #1;
    check("frz_rel_done", 32'(b_stall_id), 0);

    // ---- ext_stall holds fwd_sel; hazard under ext_stall still stalls (A)
    do_reset();
    id_valid = 1'b1; id_rs = {5'd5, 5'd0}; id_rs_used = 2'b10;
    id_ex_rd = 5'd5; id_ex_regwrite = 1'b1;
    tick();
    check("hold_sel_pre", 32'(a_fwd_sel), 'h8);
    set_load_hazard();
    ext_stall = 1'b1;
    #1;
    check("hold_hazard_stall", 32'(a_stall_id), 1);
    tick();
    tick();
    check("hold_sel", 32'(a_fwd_sel), 'h8);
    check("hold_stall_cycles", 32'(a_stall_cycles), 0);
    check("hold_events", 32'(a_fwd_events), 1);
    ext_stall = 1'b0;
    #1;
    check("hold_rel_bubble", 32'(a_bubble), 1);
    tick();
    check("hold_rel_sel", 32'(a_fwd_sel), 0);
    check("hold_rel_cycles", 32'(a_stall_cycles), 1);

    // ---- reset asserted mid-stall (B)
    do_reset();
    set_load_hazard();
    tick();
    quiet();
    #1;
    check("rstmid_in_stall", 32'(b_stall_id), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rstmid_stall_if", 32'(b_stall_if), 0);
    check("rstmid_stall_id", 32'(b_stall_id), 0);
    check("rstmid_bubble", 32'(b_bubble), 0);

    // ---- counter saturation, CNT_W=2 (C)
    do_reset();
    id_valid = 1'b1; id_rs = {5'd0, 5'd5}; id_rs_used = 2'b01;
    id_ex_rd = 5'd5; id_ex_regwrite = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("sat_events_%0d", i), 32'(c_fwd_events), (i < 3) ? i + 1 : 3);
    end
    id_ex_memread = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("sat_stall_%0d", i), 32'(c_stall_id), 1);
      tick();
    end
    check("sat_stall_cycles", 32'(c_stall_cycles), 3);
    check("sat_events_hold", 32'(c_fwd_events), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_hazard_ctrl_unit
